cpu_prog_feeder: RTL and testbench

CPU_PROG_FEEDER -- requirements
Module: cpu_prog_feeder

---
 rtl/cpu_prog_feeder.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_prog_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prog_feeder.sv
// Feeds host instruction/data bytes to a small CPU one byte per cycle, inserting
// NOP filler, keeping opcode/operand pairs adjacent and capturing output results.
module cpu_prog_feeder #(
    parameter logic [7:0] NOP_BYTE  = 8'hF0,
    parameter int         RES_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] cpu_in,
    output logic       cpu_reset,
    input  logic [7:0] cpu_out,
    output logic [7:0] r_data,
    output logic       r_valid,
    input  logic       r_ready,
    output logic       busy
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DATA = 2'd2,
        ST_PAD  = 2'd3
    } state_t;

    function automatic logic f_is_two(input logic [7:0] b);
        case (b[7:4])
            4'h6, 4'h7, 4'h8: f_is_two = 1'b1;
            default:          f_is_two = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_pad(input logic [7:0] b);
        case (b[7:4])
            4'hA, 4'hC: f_is_pad = 1'b1;
            default:    f_is_pad = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_out(input logic [7:0] b);
        case (b[7:4])
            4'hB, 4'hC: f_is_out = 1'b1;
            default:    f_is_out = 1'b0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RES_DEPTH - 1)) begin
            f_ptr_inc = {PTR_W{1'b0}};
        end else begin
            f_ptr_inc = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cpu_in;
    logic [7:0]       w_cpu_in_nxt;
    logic [7:0]       r_hold_op;
    logic [7:0]       w_hold_op_nxt;
    logic [7:0]       r_data_lat;
    logic [7:0]       w_data_lat_nxt;
    logic             r_iss_b;
    logic             r_iss_c;
    logic             w_iss_b_nxt;
    logic             w_iss_c_nxt;
    logic [2:0]       r_cap_sr;
    logic             r_cpu_reset;
    logic             r_rst_seen;
    logic             w_s_ready;

    logic [7:0]       r_mem [RES_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [2:0]       w_pending;
    logic [31:0]      w_committed;
    logic             w_credit_ok;

    // Captures still owed: scheduled in the shift line plus an output opcode on cpu_in now.
    assign w_pending   = {2'b00, r_cap_sr[0]} + {2'b00, r_cap_sr[1]} + {2'b00, r_cap_sr[2]}
                       + {2'b00, r_iss_b} + {2'b00, r_iss_c};
    assign w_committed = 32'(r_count) + 32'(w_pending);
    assign w_credit_ok = (w_committed < 32'(RES_DEPTH));

    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_full  = (r_count == CNT_W'(RES_DEPTH));
    assign w_push  = r_cap_sr[0] & ~w_full;
    assign w_pop   = ~w_empty & r_ready;

    // Next-state, next cpu_in byte and handshake decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cpu_in_nxt   = NOP_BYTE;
        w_hold_op_nxt  = r_hold_op;
        w_data_lat_nxt = r_data_lat;
        w_iss_b_nxt    = 1'b0;
        w_iss_c_nxt    = 1'b0;
        w_s_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cpu_reset) begin
                    w_s_ready = 1'b0;
                end else if (f_is_out(s_data)) begin
                    w_s_ready = w_credit_ok;
                end else begin
                    w_s_ready = 1'b1;
                end
                if (s_valid && w_s_ready) begin
                    if (f_is_two(s_data)) begin
                        w_hold_op_nxt = s_data;
                        w_state_nxt   = ST_HOLD;
                    end else begin
                        w_cpu_in_nxt = s_data;
                        w_iss_b_nxt  = (s_data[7:4] == 4'hB);
                        w_iss_c_nxt  = (s_data[7:4] == 4'hC);
                        if (f_is_pad(s_data)) begin
                            w_state_nxt = ST_PAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_s_ready = 1'b1;
                // The opcode is only released once its operand is in hand.
                if (s_valid) begin
                    w_cpu_in_nxt   = r_hold_op;
                    w_data_lat_nxt = s_data;
                    w_state_nxt    = ST_DATA;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DATA: begin
                w_cpu_in_nxt = r_data_lat;
                w_state_nxt  = ST_IDLE;
            end
            ST_PAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, issued byte and capture timing line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cpu_in   <= NOP_BYTE;
            r_hold_op  <= 8'h00;
            r_data_lat <= 8'h00;
            r_iss_b    <= 1'b0;
            r_iss_c    <= 1'b0;
            r_cap_sr   <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_cpu_in   <= w_cpu_in_nxt;
            r_hold_op  <= w_hold_op_nxt;
            r_data_lat <= w_data_lat_nxt;
            r_iss_b    <= w_iss_b_nxt;
            r_iss_c    <= w_iss_c_nxt;
            r_cap_sr   <= {r_iss_c, r_cap_sr[2] | r_iss_b, r_cap_sr[1]};
        end
    end

    // CPU reset stretcher: held through the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_seen  <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_rst_seen  <= 1'b1;
            r_cpu_reset <= ~r_rst_seen;
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cpu_out;
                r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    assign s_ready   = w_s_ready;
    assign cpu_in    = r_cpu_in;
    assign cpu_reset = r_cpu_reset;
    assign r_valid   = ~w_empty;
    assign r_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign busy      = (r_state != ST_IDLE) | (w_pending != 3'd0);

endmodule

// File: tb/tb_cpu_prog_feeder.sv
// Randomized and directed bench for cpu_prog_feeder against a queue-based issue/capture model.
module tb_cpu_prog_feeder;

    localparam logic [7:0] NOP   = 8'hF0;
    localparam int         DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] cpu_in;
    logic       cpu_reset;
    logic [7:0] cpu_out;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ready;
    logic       busy;

    cpu_prog_feeder #(.NOP_BYTE(8'hF0), .RES_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cpu_in(cpu_in), .cpu_reset(cpu_reset), .cpu_out(cpu_out),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic v; logic [7:0] d; } stim_t;
    typedef struct packed { logic op; logic [7:0] b; } iss_t;

    stim_t      stim_q[$];
    iss_t       sched_q[$];
    int         cap_q[$];
    logic [7:0] res_q[$];
    logic       holding;
    logic [7:0] hold_b;
    int         cyc;
    int         edges;
    int         rr_mode;
    logic       no_rand;
    int         vectors;
    int         miscompares;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %02h expected %02h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic is_two(input logic [7:0] b);
        return (b[7:4] == 4'h6) || (b[7:4] == 4'h7) || (b[7:4] == 4'h8);
    endfunction

    function automatic logic is_pad(input logic [7:0] b);
        return (b[7:4] == 4'hA) || (b[7:4] == 4'hC);
    endfunction

    function automatic logic is_out(input logic [7:0] b);
        return (b[7:4] == 4'hB) || (b[7:4] == 4'hC);
    endfunction

    task automatic model_reset();
        stim_q.delete();
        sched_q.delete();
        cap_q.delete();
        res_q.delete();
        holding = 1'b0;
        hold_b  = 8'h00;
    endtask

    task automatic push_stim(input logic v, input logic [7:0] d);
        stim_t s;
        s.v = v;
        s.d = d;
        stim_q.push_back(s);
    endtask

    // One clock cycle: entered at posedge+1, leaves at the next posedge+1.
    task automatic run_cycle();
        iss_t       it;
        stim_t      st;
        logic [7:0] exp_in;
        logic       exp_cr;
        logic       exp_sr;
        logic       exp_busy;
        logic       xfer;
        exp_cr = (edges < 2);
        if (sched_q.size() > 0) begin
            it     = sched_q.pop_front();
            exp_in = it.b;
            if (it.op && it.b[7:4] == 4'hB) cap_q.push_back(cyc + 2);
            if (it.op && it.b[7:4] == 4'hC) cap_q.push_back(cyc + 3);
        end else begin
            exp_in = NOP;
        end
        if (stim_q.size() == 0) begin
            if (no_rand) push_stim(1'b0, 8'h00);
            else         push_stim(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        st      = stim_q[0];
        s_valid = st.v;
        s_data  = st.d;
        r_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 2);
        cpu_out = 8'($urandom);
        if (holding)                 exp_sr = 1'b1;
        else if (sched_q.size() > 0) exp_sr = 1'b0;
        else if (exp_cr)             exp_sr = 1'b0;
        else if (is_out(st.d))       exp_sr = ((res_q.size() + cap_q.size()) < DEPTH);
        else                         exp_sr = 1'b1;
        exp_busy = holding || (sched_q.size() > 0) || (cap_q.size() > 0);

        @(negedge clk);
        check_eq("cpu_in", cpu_in, exp_in);
        check_eq("cpu_reset", {7'd0, cpu_reset}, {7'd0, exp_cr});
        check_eq("s_ready", {7'd0, s_ready}, {7'd0, exp_sr});
        check_eq("busy", {7'd0, busy}, {7'd0, exp_busy});
        check_eq("r_valid", {7'd0, r_valid}, {7'd0, (res_q.size() > 0)});
        check_eq("r_data", r_data, (res_q.size() > 0) ? res_q[0] : 8'h00);

        xfer = st.v && exp_sr;
        if (r_ready && res_q.size() > 0) void'(res_q.pop_front());
        if (cap_q.size() > 0 && cap_q[0] == cyc) begin
            void'(cap_q.pop_front());
            res_q.push_back(cpu_out);
        end
        if (xfer) begin
            void'(stim_q.pop_front());
            if (holding) begin
                sched_q.push_back({1'b1, hold_b});
                sched_q.push_back({1'b0, st.d});
                holding = 1'b0;
            end else if (is_two(st.d)) begin
                holding = 1'b1;
                hold_b  = st.d;
            end else if (is_pad(st.d)) begin
                sched_q.push_back({1'b1, st.d});
                sched_q.push_back({1'b0, NOP});
            end else begin
                sched_q.push_back({1'b1, st.d});
            end
        end else if (!st.v) begin
            void'(stim_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        edges++;
    endtask

    // Run until all queued stimulus, issues and results have drained.
    task automatic settle();
        int n;
        n = 0;
        while ((stim_q.size() != 0 || sched_q.size() != 0 || cap_q.size() != 0 ||
                res_q.size() != 0 || holding) && n < 80) begin
            run_cycle();
            n++;
        end
        check_eq("settle_timeout", {7'd0, (n < 80)}, 8'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cpu_in"}, cpu_in, NOP);
        check_eq({tag, "_cpu_reset"}, {7'd0, cpu_reset}, 8'd1);
        check_eq({tag, "_s_ready"}, {7'd0, s_ready}, 8'd0);
        check_eq({tag, "_r_valid"}, {7'd0, r_valid}, 8'd0);
        check_eq({tag, "_r_data"}, r_data, 8'h00);
        check_eq({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        edges       = 0;
        rr_mode     = 0;
        no_rand     = 1'b0;
        reset       = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'hB0;
        r_ready     = 1'b1;
        cpu_out     = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        edges = 0;

        repeat (1500) run_cycle();

        // Directed scenarios on a drained, idle block.
        stim_q.delete();
        no_rand = 1'b1;
        rr_mode = 2;
        push_stim(1'b1, 8'h00);
        settle();

        push_stim(1'b1, 8'h60); push_stim(1'b1, 8'h05); push_stim(1'b1, 8'h70);
        push_stim(1'b1, 8'h03); push_stim(1'b1, 8'h00); push_stim(1'b1, 8'hB0);
        settle();

        push_stim(1'b1, 8'h85); push_stim(1'b1, 8'h3C); push_stim(1'b1, 8'hC5);
        settle();

        push_stim(1'b1, 8'h60);
        repeat (5) push_stim(1'b0, 8'h00);
        push_stim(1'b1, 8'h11);
        settle();

        rr_mode = 1;
        repeat (3) push_stim(1'b1, 8'hB0);
        repeat (12) run_cycle();
        rr_mode = 2;
        run_cycle();
        rr_mode = 1;
        repeat (6) run_cycle();
        rr_mode = 2;
        settle();

        // Reset during the pad cycle of 0xA3 with a 0xB0 capture still owed.
        push_stim(1'b1, 8'hB0);
        push_stim(1'b1, 8'hA3);
        repeat (3) run_cycle();
        check_eq("pad_busy", {7'd0, busy}, 8'd1);
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        edges = 0;
        repeat (12) run_cycle();

        no_rand = 1'b0;
        rr_mode = 0;
        repeat (1500) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
